axis_frame_tx: RTL
==================

Name: axis_frame_tx

Overview:
- AXI-Stream-style master (transmitter) that produces framed data bursts into any valid/ready slave, such as the team's stream FIFO input port.
- A single-entry command port accepts {start value, beat count}. The block emits an incrementing-word frame with a last-beat marker and honours backpressure.
- Used as a traffic source for FIFO/interconnect bring-up and as a descriptor-driven stream generator in the datapath.

Parameters:
- DATA_WIDTH, 32, width of stream data and cmd_start.
- LEN_WIDTH, 16, width of cmd_len (beats per frame, unsigned).
- CNT_WIDTH, 16, width of the completed-frame counter.

Ports:
- aclk  input  1  clock, all logic on rising edge
- aresetn  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when high with cmd_valid
- cmd_start  input  DATA_WIDTH  first data word of frame
- cmd_len  input  LEN_WIDTH  number of payload beats (0 allowed)
- m_data  output  DATA_WIDTH  stream data
- m_valid  output  1  stream data valid
- m_last  output  1  final beat of frame
- m_ready  input  1  downstream ready
- busy  output  1  frame in progress (state != IDLE)
- done  output  1  one-cycle pulse after final beat transfer
- frame_cnt  output  CNT_WIDTH  completed frames, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset is asynchronous and active-low; aclk is the clock. Asserting aresetn low forces state=IDLE, m_valid=0, m_last=0, m_data=0, done=0, busy=0, frame_cnt=0, and clears the internal beat counter. cmd_ready is 1 in the first cycle after release.
- Reset mid-frame: outputs drop immediately (async). The partial frame is abandoned with no m_last, and the command is lost.
- States: IDLE, SEND (plus SUM with the optional feature).
- cmd_ready = (state==IDLE). All stream outputs are registered.
- IDLE: on cmd_valid && cmd_ready, latch cmd_start/cmd_len.
  - len>0: go to SEND; next cycle m_valid=1, m_data=cmd_start, m_last=(len==1). This is 1-cycle latency from command accept to first valid.
  - len==0: stay IDLE, emit no beats, pulse done next cycle, frame_cnt++.
- SEND: a transfer occurs on m_valid && m_ready.
  - On each transfer: m_data += 1 (modulo 2^DATA_WIDTH, wraps silently) and beats_left -= 1.
  - m_last is set on the beat where beats_left==1.
  - While m_valid && !m_ready, m_data and m_last are held stable. m_valid never drops once asserted until the transfer completes.
  - Transfer with m_last=1: m_valid=0 and m_last=0 next cycle, state goes to IDLE, done=1 for one cycle, frame_cnt++.
- Back-to-back commands leave one bubble cycle: cmd_ready rises the cycle after the final beat, so the next frame's first valid comes at the earliest 2 cycles after the final beat.
- cmd inputs are ignored while busy. cmd_len is sampled only at accept.
- m_ready is ignored when m_valid=0.
- Throughput: 1 beat/cycle with m_ready held high.

Optional Feature:
- Macro: AXIS_TX_SUM_EN.
- Defined: after the final payload beat, the block enters SUM and emits one extra beat. m_data = running sum of all payload words modulo 2^DATA_WIDTH. m_last moves to this checksum beat (payload beats then carry m_last=0).
  - len==0 emits a single checksum beat of 0 with m_last=1.
  - done and frame_cnt update after the checksum beat transfers.
  - The checksum beat obeys the same hold rules under backpressure.
- Undefined: no SUM state and no adder; behaviour is exactly as described above.

Test Plan:
- Reset release, cmd start=0x10, len=4, m_ready=1 -> m_data 0x10,0x11,0x12,0x13 on consecutive cycles, m_last only on 0x13, done pulse next cycle, frame_cnt=1.
- Same command with m_ready toggling 1,0,0,1,... -> no duplicated or skipped words; m_data/m_last stable during every stall cycle; m_valid never drops mid-frame.
- cmd start=0xFFFFFFFE, len=3 -> data 0xFFFFFFFE,0xFFFFFFFF,0x00000000, last on 0x0.
- len=0 command -> no m_valid; done pulse; frame_cnt increments; cmd_ready high again next cycle. With AXIS_TX_SUM_EN -> single beat data=0, m_last=1.
- Two queued commands (len=2 each) with cmd_valid held -> second accepted the cycle after first frame's last beat; exactly one idle cycle between frames; frame_cnt=2.
- aresetn pulsed low on beat 2 of len=8 frame -> m_valid=0 immediately, busy=0, frame_cnt=0, no m_last. A new command after release runs normally. With AXIS_TX_SUM_EN, len=3 start=1 -> trailing beat 6 with m_last.

Source files
------------

// File: rtl/axis_frame_tx.sv
// Descriptor-driven AXI-Stream frame generator: emits cmd_len incrementing words from cmd_start.
// Define AXIS_TX_SUM_EN to append a checksum beat (sum of payload words) carrying m_last.
module axis_frame_tx #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_start,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  frame_cnt
);

`ifdef AXIS_TX_SUM_EN
    typedef enum logic [1:0] {StIdle, StSend, StSum} state_e;
`else
    typedef enum logic [0:0] {StIdle, StSend} state_e;
`endif

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [LEN_WIDTH-1:0]  left_q, left_d;
    logic                  done_q, done_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
`ifdef AXIS_TX_SUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif
    logic                  xfer;

    assign xfer = valid_q && m_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        left_d  = left_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
`ifdef AXIS_TX_SUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    if (cmd_len != '0) begin
                        state_d = StSend;
                        valid_d = 1'b1;
                        data_d  = cmd_start;
                        left_d  = cmd_len;
`ifdef AXIS_TX_SUM_EN
                        last_d  = 1'b0;
                        sum_d   = '0;
`else
                        last_d  = (cmd_len == LEN_WIDTH'(1));
`endif
                    end else begin
`ifdef AXIS_TX_SUM_EN
                        // Empty frame still carries a zero checksum beat.
                        state_d = StSum;
                        valid_d = 1'b1;
                        data_d  = '0;
                        last_d  = 1'b1;
`else
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + CNT_WIDTH'(1);
`endif
                    end
                end
            end
            StSend: begin
                if (xfer) begin
                    left_d = left_q - LEN_WIDTH'(1);
`ifdef AXIS_TX_SUM_EN
                    sum_d  = sum_q + data_q;
                    if (left_q == LEN_WIDTH'(1)) begin
                        state_d = StSum;
                        data_d  = sum_q + data_q;
                        last_d  = 1'b1;
                    end else begin
                        data_d  = data_q + DATA_WIDTH'(1);
                    end
`else
                    data_d = data_q + DATA_WIDTH'(1);
                    if (last_q) begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + CNT_WIDTH'(1);
                    end else begin
                        last_d  = (left_q == LEN_WIDTH'(2));
                    end
`endif
                end
            end
`ifdef AXIS_TX_SUM_EN
            StSum: begin
                if (xfer) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            left_q  <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef AXIS_TX_SUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            left_q  <= left_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
`ifdef AXIS_TX_SUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign m_data    = data_q;
    assign m_valid   = valid_q;
    assign m_last    = last_q;
    assign done      = done_q;
    assign frame_cnt = cnt_q;

endmodule
